// File: rtl/arm_mem_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM encoding,
// byte-lane enable patterns and the default access timeout.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0]  BEN_WORD = 4'b1111;
  localparam logic [3:0]  BEN_LO   = 4'b0011;
  localparam logic [3:0]  BEN_HI   = 4'b1100;

  // Default number of ACCESS cycles tolerated before the access is abandoned.
  localparam int unsigned WAIT_MAX_DEFAULT = 15;

  // Clears the byte offset of a byte address to form a word address.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_lane_pack.sv
// Byte-lane handling for the memory port: store-data replication and lane
// enables on the write side, half selection with zero extension on the read
// side. Purely combinational.
module mem_lane_pack
  import arm_mem_pkg::*;
(
  input  logic        is_data,
  input  logic        half,
  input  logic        hi,
  input  logic [31:0] wdata,
  output logic [3:0]  ben,
  output logic [31:0] wdata_packed,
  input  logic        rd_half,
  input  logic        rd_hi,
  input  logic [31:0] rdata_raw,
  output logic [31:0] rdata_ext
);

  // Write side: fetches carry no data, halfwords are copied into both halves
  // so the lane enables alone pick where they land.
  always_comb begin
    ben          = BEN_WORD;
    wdata_packed = '0;
    if (is_data) begin
      wdata_packed = wdata;
      if (half) begin
        ben          = hi ? BEN_HI : BEN_LO;
        wdata_packed = {wdata[15:0], wdata[15:0]};
      end
    end
  end

  // Read side: halfword loads return the addressed half, zero-extended.
  always_comb begin
    rdata_ext = rdata_raw;
    if (rd_half) begin
      rdata_ext = {16'h0000, (rd_hi ? rdata_raw[31:16] : rdata_raw[15:0])};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port. One access is
// in flight at a time; conflicts alternate so neither port starves, and an
// access that never sees mem_ready is abandoned after WAIT_MAX cycles.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_half,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_ben,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next, wait_inc;
  logic        last_d_reg, last_d_next;
  logic        owner_d_reg, owner_d_next;
  logic        half_reg, half_next, hi_reg, hi_next;
  logic        if_gnt_reg, if_gnt_next, d_gnt_reg, d_gnt_next;
  logic        if_done_reg, if_done_next, d_done_reg, d_done_next;
  logic [31:0] if_rdata_reg, if_rdata_next, d_rdata_reg, d_rdata_next;
  logic        err_reg, err_next;
  logic        mem_cs_reg, mem_cs_next, mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next, mem_wdata_reg, mem_wdata_next;
  logic [3:0]  mem_ben_reg, mem_ben_next;
  logic        pick_d, finish, resp_err;
  logic [31:0] resp_data;
  logic [3:0]  pack_ben;
  logic [31:0] pack_wdata, rd_ext;

  // Data wins a conflict unless it also won the previous grant.
  assign pick_d   = d_req & (~if_req | ~last_d_reg);
  assign wait_inc = wait_cnt_reg + 8'd1;

  mem_lane_pack u_lane (
    .is_data      (pick_d),
    .half         (d_half),
    .hi           (d_addr[1]),
    .wdata        (d_wdata),
    .ben          (pack_ben),
    .wdata_packed (pack_wdata),
    .rd_half      (half_reg),
    .rd_hi        (hi_reg),
    .rdata_raw    (mem_rdata),
    .rdata_ext    (rd_ext)
  );

  // Next-state and next-output logic; memory-side values are captured once at
  // grant so later port activity cannot disturb the access in flight.
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    last_d_next    = last_d_reg;
    owner_d_next   = owner_d_reg;
    half_next      = half_reg;
    hi_next        = hi_reg;
    if_gnt_next    = 1'b0;
    d_gnt_next     = 1'b0;
    if_done_next   = 1'b0;
    d_done_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    err_next       = err_reg;
    mem_cs_next    = mem_cs_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_ben_next   = mem_ben_reg;
    finish         = 1'b0;
    resp_err       = 1'b0;
    resp_data      = '0;
    case (state_reg)
      ST_IDLE: begin
        if (if_req | d_req) begin
          state_next     = ST_ACCESS;
          wait_cnt_next  = '0;
          last_d_next    = pick_d;
          owner_d_next   = pick_d;
          half_next      = pick_d & d_half;
          hi_next        = d_addr[1];
          if_gnt_next    = ~pick_d;
          d_gnt_next     = pick_d;
          mem_cs_next    = 1'b1;
          mem_we_next    = pick_d & d_we;
          mem_addr_next  = (pick_d ? d_addr : if_addr) & WORD_MASK;
          mem_wdata_next = pack_wdata;
          mem_ben_next   = pack_ben;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          finish    = 1'b1;
          resp_data = rd_ext;
        end else if (wait_inc == WAIT_LIMIT) begin
          finish   = 1'b1;
          resp_err = 1'b1;
        end else begin
          wait_cnt_next = wait_inc;
        end
        if (finish) begin
          state_next     = ST_RESP;
          err_next       = resp_err;
          mem_cs_next    = 1'b0;
          mem_we_next    = 1'b0;
          mem_addr_next  = '0;
          mem_wdata_next = '0;
          mem_ben_next   = '0;
          if (owner_d_reg) begin
            d_done_next  = 1'b1;
            d_rdata_next = resp_data;
          end else begin
            if_done_next  = 1'b1;
            if_rdata_next = resp_data;
          end
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      last_d_reg    <= 1'b0;
      owner_d_reg   <= 1'b0;
      half_reg      <= 1'b0;
      hi_reg        <= 1'b0;
      if_gnt_reg    <= 1'b0;
      d_gnt_reg     <= 1'b0;
      if_done_reg   <= 1'b0;
      d_done_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      err_reg       <= 1'b0;
      mem_cs_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_ben_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      last_d_reg    <= last_d_next;
      owner_d_reg   <= owner_d_next;
      half_reg      <= half_next;
      hi_reg        <= hi_next;
      if_gnt_reg    <= if_gnt_next;
      d_gnt_reg     <= d_gnt_next;
      if_done_reg   <= if_done_next;
      d_done_reg    <= d_done_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      err_reg       <= err_next;
      mem_cs_reg    <= mem_cs_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_ben_reg   <= mem_ben_next;
    end
  end

  assign if_gnt    = if_gnt_reg;
  assign if_done   = if_done_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_gnt     = d_gnt_reg;
  assign d_done    = d_done_reg;
  assign d_rdata   = d_rdata_reg;
  assign err       = err_reg;
  assign mem_cs    = mem_cs_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_ben   = mem_ben_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: each issued request pushes its
// expected memory-side view and response; a memory responder and a done
// monitor pop and compare independently of the stimulus.
module tb_mem_port_arbiter;

  localparam int WM = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, d_half, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_done, d_gnt, d_done, err, mem_cs, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_ben;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_half(d_half), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ben(mem_ben), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] byte_addr;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  ben;
    logic [31:0] wdata;
    int          lat;        // ACCESS cycle in which memory answers; > WM never
    logic [31:0] mem_word;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } acc_t;

  acc_t        mem_q[$];
  acc_t        rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          txn_no = 0;
  bit          model_last_d = 1'b0;
  logic [31:0] held_if = '0;
  logic [31:0] held_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference view of one access, derived from the port rules with plain arithmetic.
  function automatic acc_t mk(bit is_d, logic [31:0] ia, logic dwe, logic dh,
                              logic [31:0] da, logic [31:0] dw, int lat, logic [31:0] word);
    acc_t a;
    bit   half, upper;
    a.is_d      = is_d;
    a.byte_addr = is_d ? da : ia;
    half        = is_d && dh;
    upper       = (a.byte_addr % 4) >= 2;
    a.addr      = a.byte_addr - (a.byte_addr % 4);
    a.we        = is_d && dwe;
    a.ben       = !half ? 4'hF : (upper ? 4'hC : 4'h3);
    a.wdata     = half ? (dw % 65536) * 32'h0001_0001 : dw;
    a.lat       = lat;
    a.mem_word  = word;
    a.exp_err   = (lat > WM);
    if (a.exp_err)  a.exp_rdata = '0;
    else if (half)  a.exp_rdata = upper ? word / 65536 : word % 65536;
    else            a.exp_rdata = word;
    return a;
  endfunction

  function automatic int exp_cycles(int lat);
    return (lat > WM) ? WM : lat;
  endfunction

  task automatic expect_acc(input acc_t a);
    mem_q.push_back(a);
    rsp_q.push_back(a);
  endtask

  task automatic check_outputs_zero(input string pfx);
    chk({pfx, "_if_gnt"},    32'(if_gnt),   32'd0);
    chk({pfx, "_if_done"},   32'(if_done),  32'd0);
    chk({pfx, "_if_rdata"},  if_rdata,      32'd0);
    chk({pfx, "_d_gnt"},     32'(d_gnt),    32'd0);
    chk({pfx, "_d_done"},    32'(d_done),   32'd0);
    chk({pfx, "_d_rdata"},   d_rdata,       32'd0);
    chk({pfx, "_err"},       32'(err),      32'd0);
    chk({pfx, "_mem_cs"},    32'(mem_cs),   32'd0);
    chk({pfx, "_mem_we"},    32'(mem_we),   32'd0);
    chk({pfx, "_mem_addr"},  mem_addr,      32'd0);
    chk({pfx, "_mem_wdata"}, mem_wdata,     32'd0);
    chk({pfx, "_mem_ben"},   32'(mem_ben),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    #1;
    check_outputs_zero("rst");
    mem_q.delete();
    rsp_q.delete();
    model_last_d = 1'b0;
    held_if = '0;
    held_d  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // kind: 0 fetch only, 1 data only, 2 both; lat_a/word_a belong to the first grant.
  task automatic issue(input int kind, input logic [31:0] ia, input logic dwe, input logic dh,
                       input logic [31:0] da, input logic [31:0] dw, input int lat_a,
                       input int lat_b, input logic [31:0] word_a, input logic [31:0] word_b,
                       input int gap);
    bit i_pend, d_pend, first_d;
    int n;
    repeat (gap) @(negedge clk);
    if (kind == 2) begin
      first_d = !model_last_d;
      expect_acc(mk(first_d, ia, dwe, dh, da, dw, lat_a, word_a));
      expect_acc(mk(!first_d, ia, dwe, dh, da, dw, lat_b, word_b));
      model_last_d = !first_d;
    end else begin
      expect_acc(mk(kind == 1, ia, dwe, dh, da, dw, lat_a, word_a));
      model_last_d = (kind == 1);
    end
    if_addr = ia; d_we = dwe; d_half = dh; d_addr = da; d_wdata = dw;
    i_pend = (kind != 1);
    d_pend = (kind != 0);
    if_req = i_pend;
    d_req  = d_pend;
    n = 0;
    while ((i_pend || d_pend) && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1 && gap > 0) chk("cs_rise_after_req", 32'(mem_cs), 32'd1);
      // Granted port's inputs are scrambled: the access must not notice.
      if (if_gnt) if_addr = $urandom;
      if (d_gnt) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom); d_half = 1'($urandom);
      end
      if (if_done) begin if_req = 1'b0; i_pend = 1'b0; end
      if (d_done)  begin d_req  = 1'b0; d_pend = 1'b0; end
    end
    if (i_pend || d_pend) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no done after %0d cycles, expected done", n);
      do_reset();
    end
  endtask

  // Memory responder and memory-side scoreboard.
  initial begin : responder
    int   k;
    acc_t cur;
    k = 0;
    cur = mk(1'b0, '0, 1'b0, 1'b0, '0, '0, 1, '0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_cs) begin
        if (k == 0) begin
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: got mem_cs=1 addr=%h expected no access", mem_addr);
            cur = mk(1'b0, '0, 1'b0, 1'b0, '0, '0, 1, '0);
          end else begin
            cur = mem_q.pop_front();
          end
          chk("gnt_owner", {30'd0, if_gnt, d_gnt}, cur.is_d ? 32'd1 : 32'd2);
        end else begin
          chk("gnt_single_pulse", {30'd0, if_gnt, d_gnt}, 32'd0);
        end
        k++;
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_ben", 32'(mem_ben), 32'(cur.ben));
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        if (cur.is_d) chk("mem_wdata", mem_wdata, cur.wdata);
        mem_ready = (k == cur.lat);
        mem_rdata = (k == cur.lat) ? cur.mem_word : $urandom;
      end else begin
        if (k != 0 && rst_n) chk("access_cycles", k, exp_cycles(cur.lat));
        k = 0;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Response-side scoreboard.
  initial begin : done_mon
    bit   prev_done;
    logic prev_cs;
    acc_t r;
    prev_done = 1'b0;
    prev_cs   = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("no_grant_in_resp", {30'd0, if_gnt, d_gnt}, 32'd0);
      if (if_done || d_done) begin
        chk("done_follows_access", {30'd0, prev_cs, mem_cs}, 32'd2);
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got if_done=%b d_done=%b expected none", if_done, d_done);
        end else begin
          r = rsp_q.pop_front();
          chk("done_owner", {30'd0, if_done, d_done}, r.is_d ? 32'd1 : 32'd2);
          chk("err", 32'(err), 32'(r.exp_err));
          if (r.is_d) begin
            chk("d_rdata", d_rdata, r.exp_rdata);
            chk("if_rdata_hold", if_rdata, held_if);
            held_d = r.exp_rdata;
          end else begin
            chk("if_rdata", if_rdata, r.exp_rdata);
            chk("d_rdata_hold", d_rdata, held_d);
            held_if = r.exp_rdata;
          end
          txn_no++;
          $display("txn %0d: %s addr=%h lat=%0d rdata=%h err=%b", txn_no,
                   r.is_d ? "D" : "I", r.byte_addr, r.lat, r.exp_rdata, r.exp_err);
        end
      end
      prev_done = if_done || d_done;
      prev_cs   = mem_cs;
    end
  end

  initial begin : main
    int n;
    int kind, lat;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_half = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Conflicts straight after reset: D, I, D, I.
    issue(2, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 1, 2, 32'hA1A1_0001, 32'hB2B2_0002, 1);
    issue(2, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0084, 32'h1357_9BDF, 2, 1, 32'h0, 32'hC3C3_0003, 1);
    // Fetch at an unaligned address, ready in the second ACCESS cycle.
    issue(0, 32'h0000_0106, 1'b0, 1'b0, 32'h0, 32'h0, 2, 0, 32'hDEAD_0106, 32'h0, 1);
    // Halfword store to the upper half, halfword load from the lower half.
    issue(1, 32'h0, 1'b1, 1'b1, 32'h0000_0202, 32'h0000_BEEF, 1, 0, 32'h0, 32'h0, 1);
    issue(1, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 1, 0, 32'h1234_5678, 32'h0, 1);
    issue(1, 32'h0, 1'b0, 1'b1, 32'h0000_0202, 32'h0, 3, 0, 32'h1234_5678, 32'h0, 0);
    // Timeout, then ready exactly in the last permitted cycle.
    issue(1, 32'h0, 1'b0, 1'b0, 32'h0000_0300, 32'h0, WM + 1, 0, 32'h5555_AAAA, 32'h0, 1);
    issue(0, 32'h0000_0400, 1'b0, 1'b0, 32'h0, 32'h0, WM, 0, 32'h7777_8888, 32'h0, 1);

    // Reset in the middle of an access: no done, outputs cleared.
    @(negedge clk);
    expect_acc(mk(1'b1, '0, 1'b0, 1'b0, 32'h0000_0500, '0, 40, 32'hCAFE_F00D));
    model_last_d = 1'b1;
    d_addr = 32'h0000_0500; d_we = 1'b0; d_half = 1'b0; d_req = 1'b1;
    n = 0;
    while (!mem_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_access_started", 32'(mem_cs), 32'd1);
    repeat (3) @(negedge clk);
    do_reset();
    // After reset the next conflict must again go to data first.
    issue(2, 32'h0000_0600, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 1, 1, 32'h0102_0304, 32'h0506_0708, 1);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      lat = ($urandom_range(0, 4) == 0) ? $urandom_range(WM - 2, WM + 2) : $urandom_range(1, 4);
      issue(kind, $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom,
            lat, $urandom_range(1, 4), $urandom, $urandom, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("mem_q_drained", mem_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
